// File: rtl/ddr_fifo_pkg.sv
// Shared definitions for the DDR2 FIFO read path: FSM encoding, burst geometry
// and error-bit positions.
package ddr_fifo_pkg;

  // 4 bits wide so the encoding lines up with the command generator's state.
  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_RUN   = 4'd1,
    ST_DRAIN = 4'd2,
    ST_ERR   = 4'd3
  } rd_state_t;

  localparam int ERR_UNEXP   = 0;
  localparam int ERR_OVF     = 1;
  localparam int ERR_TIMEOUT = 2;
  localparam int ERR_N       = 3;

  // App-side beats per read command: each app word carries two DQ transfers.
  function automatic int beats_of(input int write_burst);
    return write_burst / 2;
  endfunction

endpackage

// File: rtl/ddr_rd_return_if.sv
// Bundle between the memory controller read port, the command generator and
// the output FIFO write port. master drives the block's inputs, slave is the block.
interface ddr_rd_return_if #(
  parameter int DATA_WIDTH = 64
);
  logic                      phy_init_done;
  logic                      enable;
  logic                      rd_addr_en;
  logic                      rd_data_valid;
  logic [2*DATA_WIDTH-1:0]   rd_data_fifo_out;
  logic [9:0]                out_wr_count;
  logic                      out_full;
  logic                      rd_en;
  logic                      out_wr;
  logic [2*DATA_WIDTH-1:0]   out_din;
  logic [3:0]                outstanding;
  logic                      busy;
  logic                      err_unexp;
  logic                      err_ovf;
  logic                      err_timeout;

  modport master (
    output phy_init_done, enable, rd_addr_en, rd_data_valid, rd_data_fifo_out,
           out_wr_count, out_full,
    input  rd_en, out_wr, out_din, outstanding, busy, err_unexp, err_ovf, err_timeout
  );

  modport slave (
    input  phy_init_done, enable, rd_addr_en, rd_data_valid, rd_data_fifo_out,
           out_wr_count, out_full,
    output rd_en, out_wr, out_din, outstanding, busy, err_unexp, err_ovf, err_timeout
  );
endinterface

// File: rtl/rd_credit_cnt.sv
// Read-credit bookkeeping: commands in flight, beat position within the current
// burst, and whether one more read may be granted without risking FIFO overflow.
module rd_credit_cnt
  import ddr_fifo_pkg::*;
#(
  parameter int BEATS           = 4,
  parameter int MAX_OUTSTANDING = 8,
  parameter int FIFO_DEPTH      = 1024
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       rd_addr_en_i,
  input  logic       rd_data_valid_i,
  input  logic       rd_en_i,
  input  logic [9:0] out_wr_count_i,
  output logic [3:0] outstanding_o,
  output logic       grant_ok_o,
  output logic       sat_err_o
);
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int RES_W = 16;

  logic [3:0]       outstanding_q, outstanding_d;
  logic [BW-1:0]    beat_q, beat_d;
  logic             last_beat, inc, dec, at_max;
  logic [RES_W-1:0] reserved;
  logic [4:0]       inflight;

  always_comb begin
    last_beat = rd_data_valid_i && (beat_q == BW'(BEATS - 1));
    at_max    = (outstanding_q == 4'(MAX_OUTSTANDING));
    inc       = rd_addr_en_i;
    dec       = last_beat && (outstanding_q != 4'd0);
    sat_err_o = inc && !dec && at_max;

    outstanding_d = outstanding_q;
    if (inc && !dec && !at_max) outstanding_d = outstanding_q + 4'd1;
    else if (dec && !inc)       outstanding_d = outstanding_q - 4'd1;

    beat_d = beat_q;
    if (rd_data_valid_i) beat_d = last_beat ? '0 : beat_q + BW'(1);

    // A grant being consumed this cycle is not yet in outstanding_q.
    inflight   = 5'(outstanding_q) + 5'(rd_en_i && rd_addr_en_i);
    reserved   = RES_W'(out_wr_count_i) + RES_W'(outstanding_q) * RES_W'(BEATS);
    grant_ok_o = (inflight < 5'(MAX_OUTSTANDING)) &&
                 (reserved + RES_W'(2 * BEATS) <= RES_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      outstanding_q <= '0;
      beat_q        <= '0;
    end else begin
      outstanding_q <= outstanding_d;
      beat_q        <= beat_d;
    end
  end

  assign outstanding_o = outstanding_q;

endmodule

// File: rtl/ddr_rd_return.sv
// DDR2 read-return path: grants reads when downstream space is guaranteed,
// forwards controller beats to the output FIFO and raises sticky protocol errors.
module ddr_rd_return
  import ddr_fifo_pkg::*;
#(
  parameter int DATA_WIDTH      = 64,
  parameter int WRITE_BURST     = 8,
  parameter int MAX_OUTSTANDING = 8,
  parameter int FIFO_DEPTH      = 1024,
  parameter int TIMEOUT         = 255
) (
  input  logic            sys_clk,
  input  logic            reset,
  ddr_rd_return_if.slave  bus
);
  localparam int BEATS = beats_of(WRITE_BURST);
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  rd_state_t               state_q;
  logic                    rd_en_q;
  logic                    out_wr_q;
  logic [2*DATA_WIDTH-1:0] out_din_q;
  logic [ERR_N-1:0]        err_q, err_det;
  logic [WD_W-1:0]         wdog_q, wdog_d;
  logic                    wdog_fire, grant_ok, sat_err;
  logic [3:0]              outstanding;

  rd_credit_cnt #(
    .BEATS          (BEATS),
    .MAX_OUTSTANDING(MAX_OUTSTANDING),
    .FIFO_DEPTH     (FIFO_DEPTH)
  ) u_credit (
    .clk_i          (sys_clk),
    .rst_i          (reset),
    .rd_addr_en_i   (bus.rd_addr_en),
    .rd_data_valid_i(bus.rd_data_valid),
    .rd_en_i        (rd_en_q),
    .out_wr_count_i (bus.out_wr_count),
    .outstanding_o  (outstanding),
    .grant_ok_o     (grant_ok),
    .sat_err_o      (sat_err)
  );

  always_comb begin
    wdog_d    = wdog_q;
    wdog_fire = 1'b0;
    if (bus.rd_data_valid || outstanding == 4'd0) begin
      wdog_d = '0;
    end else if (wdog_q != WD_W'(TIMEOUT)) begin
      wdog_d    = wdog_q + WD_W'(1);
      wdog_fire = (wdog_q == WD_W'(TIMEOUT - 1));
    end

    err_det              = '0;
    err_det[ERR_UNEXP]   = (bus.rd_data_valid && outstanding == 4'd0) || sat_err;
    err_det[ERR_OVF]     = bus.rd_data_valid && bus.out_full;
    err_det[ERR_TIMEOUT] = wdog_fire;
  end

  // rd_en is decided alongside the next state so it drops in the same cycle ERR/DRAIN is entered.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      rd_en_q <= 1'b0;
      err_q   <= '0;
      wdog_q  <= '0;
    end else begin
      err_q  <= err_q | err_det;
      wdog_q <= wdog_d;
      if (|err_det) begin
        state_q <= ST_ERR;
        rd_en_q <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            rd_en_q <= 1'b0;
            if (bus.phy_init_done && bus.enable) begin
              state_q <= ST_RUN;
              rd_en_q <= grant_ok;
            end
          end
          ST_RUN: begin
            if (!bus.enable) begin
              state_q <= ST_DRAIN;
              rd_en_q <= 1'b0;
            end else begin
              rd_en_q <= grant_ok;
            end
          end
          ST_DRAIN: begin
            rd_en_q <= 1'b0;
            if (outstanding == 4'd0) state_q <= ST_IDLE;
          end
          default: rd_en_q <= 1'b0;
        endcase
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      out_wr_q  <= 1'b0;
      out_din_q <= '0;
    end else begin
      out_wr_q <= bus.rd_data_valid && !bus.out_full;
      if (bus.rd_data_valid && !bus.out_full) out_din_q <= bus.rd_data_fifo_out;
    end
  end

  assign bus.rd_en       = rd_en_q;
  assign bus.out_wr      = out_wr_q;
  assign bus.out_din     = out_din_q;
  assign bus.outstanding = outstanding;
  assign bus.busy        = (outstanding != 4'd0);
  assign bus.err_unexp   = err_q[ERR_UNEXP];
  assign bus.err_ovf     = err_q[ERR_OVF];
  assign bus.err_timeout = err_q[ERR_TIMEOUT];

endmodule

// File: tb/tb_ddr_rd_return.sv
// Directed bench for ddr_rd_return: stimulus pushes expected FIFO words into a
// queue, an independent monitor pops and compares on every out_wr.
module tb_ddr_rd_return;
  import ddr_fifo_pkg::*;

  logic sys_clk = 1'b0;
  logic reset   = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;
  logic [127:0] exp_q[$];

  ddr_rd_return_if #(.DATA_WIDTH(64)) bus();

  ddr_rd_return #(
    .DATA_WIDTH(64), .WRITE_BURST(8), .MAX_OUTSTANDING(8),
    .FIFO_DEPTH(1024), .TIMEOUT(255)
  ) dut (
    .sys_clk(sys_clk),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic cmd();
    bus.rd_addr_en = 1'b1;
    step();
    bus.rd_addr_en = 1'b0;
  endtask

  // One controller beat; if it is expected in the FIFO, out_wr must follow one cycle later.
  task automatic beat(input logic [127:0] d, input logic written);
    bus.rd_data_valid    = 1'b1;
    bus.rd_data_fifo_out = d;
    if (written) exp_q.push_back(d);
    step();
    bus.rd_data_valid = 1'b0;
    chk("out_wr_lag", 128'(bus.out_wr), 128'(written));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_err_unexp", 128'(bus.err_unexp), 128'(0));
    chk("rst_outstanding", 128'(bus.outstanding), 128'(0));
    step();
  endtask

  always @(negedge sys_clk) begin
    if (bus.out_wr) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL out_din: unexpected write 0x%0h, nothing queued", bus.out_din);
      end else begin
        chk("out_din", bus.out_din, exp_q.pop_front());
      end
    end
  end

  int thr_cnt[5] = '{1016, 1017, 1012, 1020, 1008};
  bit thr_exp[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    bus.phy_init_done    = 1'b0;
    bus.enable           = 1'b0;
    bus.rd_addr_en       = 1'b0;
    bus.rd_data_valid    = 1'b0;
    bus.rd_data_fifo_out = '0;
    bus.out_wr_count     = '0;
    bus.out_full         = 1'b0;
    step(2);

    chk("reset_rd_en", 128'(bus.rd_en), 128'(0));
    chk("reset_out_wr", 128'(bus.out_wr), 128'(0));
    chk("reset_out_din", bus.out_din, 128'(0));
    chk("reset_outstanding", 128'(bus.outstanding), 128'(0));
    chk("reset_busy", 128'(bus.busy), 128'(0));
    chk("reset_errs", 128'({bus.err_unexp, bus.err_ovf, bus.err_timeout}), 128'(0));
    chk("reset_state", 128'(dut.state_q), 128'(ST_IDLE));

    // Start-up grant, then fill the command window.
    reset = 1'b0;
    bus.phy_init_done = 1'b1;
    bus.enable = 1'b1;
    step();
    chk("startup_rd_en", 128'(bus.rd_en), 128'(1));
    chk("startup_state", 128'(dut.state_q), 128'(ST_RUN));
    for (int i = 0; i < 8; i++) begin
      bus.rd_addr_en = 1'b1;
      step();
      chk("fill_outstanding", 128'(bus.outstanding), 128'(i + 1));
      chk("fill_rd_en", 128'(bus.rd_en), 128'(i < 7));
    end
    bus.rd_addr_en = 1'b0;
    chk("fill_busy", 128'(bus.busy), 128'(1));
    for (int i = 0; i < 32; i++) beat(128'hD000 + 128'(i), 1'b1);
    chk("fill_drained", 128'(bus.outstanding), 128'(0));
    chk("fill_busy_low", 128'(bus.busy), 128'(0));

    // Two commands, eight back-to-back beats 1..8.
    cmd();
    cmd();
    chk("b2b_outstanding0", 128'(bus.outstanding), 128'(2));
    for (int i = 1; i <= 8; i++) begin
      beat(128'(i), 1'b1);
      chk("b2b_outstanding", 128'(bus.outstanding), 128'((i < 4) ? 2 : (i < 8) ? 1 : 0));
    end
    step();
    chk("b2b_out_wr_idle", 128'(bus.out_wr), 128'(0));
    chk("b2b_busy", 128'(bus.busy), 128'(0));

    // FIFO reservation threshold: count + 0*4 + 8 <= 1024.
    for (int i = 0; i < 5; i++) begin
      bus.out_wr_count = 10'(thr_cnt[i]);
      step();
      chk($sformatf("thr_rd_en_%0d", thr_cnt[i]), 128'(bus.rd_en), 128'(thr_exp[i]));
    end
    bus.out_wr_count = 10'd1012;
    cmd();
    chk("thr_cmd_rd_en", 128'(bus.rd_en), 128'(1));
    step();
    chk("thr_1012_out1", 128'(bus.rd_en), 128'(1));
    bus.out_wr_count = 10'd1013;
    step();
    chk("thr_1013_out1", 128'(bus.rd_en), 128'(0));
    bus.out_wr_count = 10'd0;
    for (int i = 0; i < 4; i++) beat(128'hC0 + 128'(i), 1'b1);
    chk("thr_drained", 128'(bus.outstanding), 128'(0));

    // Issue and last beat in the same cycle.
    cmd(); cmd(); cmd();
    for (int i = 0; i < 3; i++) beat(128'hB0 + 128'(i), 1'b1);
    chk("same_cyc_before", 128'(bus.outstanding), 128'(3));
    bus.rd_addr_en = 1'b1;
    beat(128'hB3, 1'b1);
    bus.rd_addr_en = 1'b0;
    chk("same_cyc_after", 128'(bus.outstanding), 128'(3));
    for (int i = 0; i < 12; i++) beat(128'hBB00 + 128'(i), 1'b1);
    chk("same_cyc_drained", 128'(bus.outstanding), 128'(0));

    // Drain: enable drops with one burst in flight.
    cmd();
    bus.enable = 1'b0;
    step();
    chk("drain_state", 128'(dut.state_q), 128'(ST_DRAIN));
    chk("drain_rd_en", 128'(bus.rd_en), 128'(0));
    for (int i = 0; i < 4; i++) beat(128'hA0 + 128'(i), 1'b1);
    chk("drain_last_state", 128'(dut.state_q), 128'(ST_DRAIN));
    step();
    chk("drain_idle", 128'(dut.state_q), 128'(ST_IDLE));
    bus.enable = 1'b1;
    step();
    chk("drain_rerun", 128'(dut.state_q), 128'(ST_RUN));

    // Unexpected data: sticky, ERR, still written to the FIFO.
    beat(128'hE1, 1'b1);
    chk("unexp_flag", 128'(bus.err_unexp), 128'(1));
    chk("unexp_state", 128'(dut.state_q), 128'(ST_ERR));
    chk("unexp_rd_en", 128'(bus.rd_en), 128'(0));
    chk("unexp_ovf_clear", 128'(bus.err_ovf), 128'(0));
    step(3);
    chk("unexp_rd_en_held", 128'(bus.rd_en), 128'(0));
    chk("unexp_state_held", 128'(dut.state_q), 128'(ST_ERR));
    beat(128'hE2, 1'b1);
    do_reset();

    // Overflow: beat dropped.
    cmd();
    bus.out_full = 1'b1;
    beat(128'hF1, 1'b0);
    bus.out_full = 1'b0;
    chk("ovf_flag", 128'(bus.err_ovf), 128'(1));
    chk("ovf_unexp_clear", 128'(bus.err_unexp), 128'(0));
    chk("ovf_state", 128'(dut.state_q), 128'(ST_ERR));
    do_reset();

    // Command beyond the window saturates the count.
    for (int i = 0; i < 8; i++) cmd();
    chk("sat_pre_err", 128'(bus.err_unexp), 128'(0));
    cmd();
    chk("sat_outstanding", 128'(bus.outstanding), 128'(8));
    chk("sat_err", 128'(bus.err_unexp), 128'(1));
    do_reset();

    // Watchdog: fires on the 255th idle cycle after the command.
    cmd();
    step(254);
    chk("timeout_early", 128'(bus.err_timeout), 128'(0));
    step();
    chk("timeout_fire", 128'(bus.err_timeout), 128'(1));
    chk("timeout_state", 128'(dut.state_q), 128'(ST_ERR));
    do_reset();

    // Reset mid-burst: stragglers afterwards are unexpected.
    cmd();
    beat(128'h71, 1'b1);
    beat(128'h72, 1'b1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_outstanding", 128'(bus.outstanding), 128'(0));
    chk("midrst_busy", 128'(bus.busy), 128'(0));
    beat(128'h73, 1'b1);
    chk("midrst_unexp", 128'(bus.err_unexp), 128'(1));

    step(3);
    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
